apb_event_sink: RTL and testbench

APB completer that terminates the event-count write stream from the event-to-APB initiator. It decodes the three event mailbox addresses and accumulates each received count into a saturating 32-bit total. The totals are readable over APB and exported as sideband outputs. Access latency is set by a programmable wait-state count. The block sits on the peripheral bus opposite the initiator, for example in a monitor or telemetry subsystem.

---
 rtl/apb_event_sink.sv | 167 ++++++++++++++++
 tb/tb_apb_event_sink.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_event_sink.sv
// APB completer that accumulates event counts written to three mailbox addresses
// into saturating 32-bit totals, readable over APB and exported as sideband outputs.
module apb_event_sink #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_A      = 32'hABBA0000,
  parameter logic [31:0] ADDR_B      = 32'hBAFF0000,
  parameter logic [31:0] ADDR_C      = 32'hCAFE0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        apb_psel_i,
  input  logic        apb_penable_i,
  input  logic [31:0] apb_paddr_i,
  input  logic        apb_pwrite_i,
  input  logic [31:0] apb_pwdata_i,
  output logic        apb_pready_o,
  output logic [31:0] apb_prdata_o,
  output logic        apb_pslverr_o,
  input  logic        clr_i,
  output logic [31:0] total_a_o,
  output logic [31:0] total_b_o,
  output logic [31:0] total_c_o,
  output logic [2:0]  sat_o
);

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 4;
  localparam int unsigned NEV = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            wr_q;
  logic            err_q;
  logic [1:0]      sel_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   total [NEV];
  logic [NEV-1:0]  sat;
  logic            pready;
  logic            pslverr;
  logic [DW-1:0]   prdata;

  logic            setup;
  logic            access;
  logic            dec_err;
  logic [1:0]      dec_sel;
  logic            go_ready;
  logic            ent_wr;
  logic            ent_err;
  logic [1:0]      ent_sel;
  logic [DW-1:0]   ent_rdata;
  logic [DW-1:0]   cur_total;
  logic [DW:0]     sum;
  logic            commit;

  // Full-width mailbox address decode of the bus address
  always_comb begin
    dec_sel = 2'd0;
    dec_err = 1'b0;
    if (apb_paddr_i == ADDR_A)      dec_sel = 2'd0;
    else if (apb_paddr_i == ADDR_B) dec_sel = 2'd1;
    else if (apb_paddr_i == ADDR_C) dec_sel = 2'd2;
    else                            dec_err = 1'b1;
  end

  // READY entry comes straight from IDLE for zero-wait, so use live decode there
  always_comb begin
    setup    = apb_psel_i && !apb_penable_i;
    access   = apb_psel_i && apb_penable_i;
    go_ready = 1'b0;
    if (state == ST_IDLE)      go_ready = setup && (WAIT_CYCLES == 0);
    else if (state == ST_WAIT) go_ready = access && (cnt == CW'(1));

    ent_wr  = (state == ST_IDLE) ? apb_pwrite_i : wr_q;
    ent_err = (state == ST_IDLE) ? dec_err      : err_q;
    ent_sel = (state == ST_IDLE) ? dec_sel      : sel_q;

    ent_rdata = '0;
    if (!ent_wr && !ent_err) begin
      case (ent_sel)
        2'd0:    ent_rdata = total[0];
        2'd1:    ent_rdata = total[1];
        2'd2:    ent_rdata = total[2];
        default: ent_rdata = '0;
      endcase
    end

    case (sel_q)
      2'd0:    cur_total = total[0];
      2'd1:    cur_total = total[1];
      2'd2:    cur_total = total[2];
      default: cur_total = '0;
    endcase
    sum    = {1'b0, cur_total} + {1'b0, wdata_q};
    commit = (state == ST_READY) && wr_q && !err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      sat     <= '0;
      for (int i = 0; i < NEV; i++) total[i] <= '0;
    end else begin
      pready  <= go_ready;
      pslverr <= go_ready && ent_err;
      prdata  <= go_ready ? ent_rdata : '0;

      case (state)
        ST_IDLE: begin
          if (setup) begin
            wr_q    <= apb_pwrite_i;
            wdata_q <= apb_pwdata_i;
            err_q   <= dec_err;
            sel_q   <= dec_sel;
            cnt     <= CW'(WAIT_CYCLES);
            state   <= (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!apb_psel_i) begin
            state <= ST_IDLE;
          end else if (apb_penable_i) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= ST_READY;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Clear wins over accumulation; a coinciding commit lands on the cleared total
      if (clr_i) begin
        sat <= '0;
        for (int i = 0; i < NEV; i++)
          total[i] <= (commit && (sel_q == 2'(i))) ? wdata_q : '0;
      end else if (commit) begin
        for (int i = 0; i < NEV; i++) begin
          if (sel_q == 2'(i)) begin
            total[i] <= sum[DW] ? '1 : sum[DW-1:0];
            if (sum[DW]) sat[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign apb_pready_o  = pready;
  assign apb_pslverr_o = pslverr;
  assign apb_prdata_o  = prdata;
  assign total_a_o     = total[0];
  assign total_b_o     = total[1];
  assign total_c_o     = total[2];
  assign sat_o         = sat;

endmodule

// File: tb/tb_apb_event_sink.sv
// Bench for apb_event_sink: three instances (0, 1 and 3 wait states) on a shared bus,
// checked against a mailbox-total model plus hand-computed expectations.
module tb_apb_event_sink;

  localparam logic [31:0] A_ADDR = 32'hABBA0000;
  localparam logic [31:0] B_ADDR = 32'hBAFF0000;
  localparam logic [31:0] C_ADDR = 32'hCAFE0000;
  localparam logic [31:0] BAD    = 32'hDEAD0000;

  logic        clk;
  logic        reset;
  logic [2:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        clr;
  logic [2:0]  pready;
  logic [2:0]  pslverr;
  logic [31:0] prdata [3];
  logic [31:0] ta [3];
  logic [31:0] tb [3];
  logic [31:0] tc [3];
  logic [2:0]  sat [3];

  int          wait_of [3] = '{0, 1, 3};
  logic [31:0] m_tot [3][3];
  logic [2:0]  m_sat [3];
  int          checks = 0;
  int          errors = 0;
  logic        busy = 1'b0;
  logic        cmp_on = 1'b0;

  apb_event_sink #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .apb_psel_i(psel[0]), .apb_penable_i(penable),
    .apb_paddr_i(paddr), .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
    .apb_pready_o(pready[0]), .apb_prdata_o(prdata[0]), .apb_pslverr_o(pslverr[0]),
    .clr_i(clr), .total_a_o(ta[0]), .total_b_o(tb[0]), .total_c_o(tc[0]), .sat_o(sat[0]));

  apb_event_sink #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .apb_psel_i(psel[1]), .apb_penable_i(penable),
    .apb_paddr_i(paddr), .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
    .apb_pready_o(pready[1]), .apb_prdata_o(prdata[1]), .apb_pslverr_o(pslverr[1]),
    .clr_i(clr), .total_a_o(ta[1]), .total_b_o(tb[1]), .total_c_o(tc[1]), .sat_o(sat[1]));

  apb_event_sink #(.WAIT_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .apb_psel_i(psel[2]), .apb_penable_i(penable),
    .apb_paddr_i(paddr), .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
    .apb_pready_o(pready[2]), .apb_prdata_o(prdata[2]), .apb_pslverr_o(pslverr[2]),
    .clr_i(clr), .total_a_o(ta[2]), .total_b_o(tb[2]), .total_c_o(tc[2]), .sat_o(sat[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (inst %0d): got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    if (a == A_ADDR) return 0;
    if (a == B_ADDR) return 1;
    if (a == C_ADDR) return 2;
    return -1;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      m_sat[d] = 3'b000;
      for (int e = 0; e < 3; e++) m_tot[d][e] = 32'd0;
    end
  endtask

  // Totals and sticky flags must follow the model on every cycle; bus idle means no response
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 3; d++) begin
        chk("total_a", d, ta[d], m_tot[d][0]);
        chk("total_b", d, tb[d], m_tot[d][1]);
        chk("total_c", d, tc[d], m_tot[d][2]);
        chk("sat", d, 32'(sat[d]), 32'(m_sat[d]));
        if (!busy) begin
          chk("idle_pready", d, 32'(pready[d]), 32'd0);
          chk("idle_prdata", d, prdata[d], 32'd0);
        end
      end
    end
  end

  // Enter and leave at posedge+1; a following call starts its setup phase back-to-back
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                      input logic [31:0] data, input logic clr_rdy);
    int          k;
    int          e;
    logic        done;
    logic [31:0] exp_rd;
    logic [32:0] s;
    e      = dec(addr);
    exp_rd = 32'd0;
    if (!wr && e >= 0) exp_rd = m_tot[d][e];
    busy    = 1'b1;
    psel[d] = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = data;
    k       = 0;
    done    = 1'b0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      penable = 1'b1;
      pwdata  = ~data;
      k++;
      @(negedge clk);
      if (pready[d] === 1'b1) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout (inst %0d): no pready after %0d access cycles", d, k);
    end else begin
      chk("latency", d, 32'(k), 32'(wait_of[d] + 1));
      chk("pslverr", d, 32'(pslverr[d]), (e < 0) ? 32'd1 : 32'd0);
      chk("prdata", d, prdata[d], exp_rd);
      if (clr_rdy) clr = 1'b1;
    end
    @(posedge clk); #1;
    psel[d] = 1'b0;
    penable = 1'b0;
    clr     = 1'b0;
    busy    = 1'b0;
    if (done) begin
      if (clr_rdy) model_clear();
      if (wr && e >= 0) begin
        s = {1'b0, m_tot[d][e]} + {1'b0, data};
        if (s > 33'h0_FFFF_FFFF) begin
          m_tot[d][e] = 32'hFFFF_FFFF;
          m_sat[d][e] = 1'b1;
        end else begin
          m_tot[d][e] = s[31:0];
        end
      end
    end
  endtask

  task automatic abort_xfer(input int d, input logic [31:0] addr, input logic [31:0] data, input int n);
    busy    = 1'b1;
    psel[d] = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = 1'b1;
    pwdata  = data;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      chk("abort_pready", d, 32'(pready[d]), 32'd0);
    end
    @(posedge clk); #1;
    psel[d] = 1'b0;
    penable = 1'b0;
    busy    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_pready"}, d, 32'(pready[d]), 32'd0);
      chk({tag, "_pslverr"}, d, 32'(pslverr[d]), 32'd0);
      chk({tag, "_prdata"}, d, prdata[d], 32'd0);
      chk({tag, "_ta"}, d, ta[d], 32'd0);
      chk({tag, "_tb"}, d, tb[d], 32'd0);
      chk({tag, "_tc"}, d, tc[d], 32'd0);
      chk({tag, "_sat"}, d, 32'(sat[d]), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; psel = 3'b000; penable = 1'b0; paddr = '0;
    pwrite = 1'b0; pwdata = '0; clr = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    cmp_on = 1'b1;
    @(posedge clk); #1;

    // one wait state: write then read mailbox A
    xfer(1, A_ADDR, 1'b1, 32'd5, 1'b0);
    chk("lit_ta_5", 1, ta[1], 32'd5);
    xfer(1, A_ADDR, 1'b0, 32'd0, 1'b0);

    // zero wait, back-to-back writes, then read straight after a write
    xfer(0, B_ADDR, 1'b1, 32'd3, 1'b0);
    xfer(0, C_ADDR, 1'b1, 32'd4, 1'b0);
    chk("lit_tb_3", 0, tb[0], 32'd3);
    chk("lit_tc_4", 0, tc[0], 32'd4);
    chk("lit_ta_0", 0, ta[0], 32'd0);
    xfer(0, A_ADDR, 1'b1, 32'd11, 1'b0);
    xfer(0, A_ADDR, 1'b0, 32'd0, 1'b0);
    chk("lit_ta_11", 0, ta[0], 32'd11);

    // saturation, zero increment, then clear
    xfer(1, A_ADDR, 1'b1, 32'hFFFF_FFEB, 1'b0);
    chk("lit_ta_fff0", 1, ta[1], 32'hFFFF_FFF0);
    xfer(1, A_ADDR, 1'b1, 32'd0, 1'b0);
    xfer(1, A_ADDR, 1'b1, 32'h20, 1'b0);
    chk("lit_ta_sat", 1, ta[1], 32'hFFFF_FFFF);
    chk("lit_sat_001", 1, 32'(sat[1]), 32'd1);
    clr_pulse();
    chk("lit_ta_clr", 1, ta[1], 32'd0);
    chk("lit_sat_clr", 1, 32'(sat[1]), 32'd0);

    // unmapped addresses, including a one-bit near miss
    xfer(1, BAD, 1'b1, 32'd7, 1'b0);
    xfer(1, BAD, 1'b0, 32'd0, 1'b0);
    xfer(1, A_ADDR | 32'd1, 1'b1, 32'd2, 1'b0);
    xfer(2, C_ADDR, 1'b1, 32'd13, 1'b0);
    xfer(2, C_ADDR ^ 32'h8000_0000, 1'b0, 32'd0, 1'b0);

    // aborted access on three wait states, then a normal write
    abort_xfer(2, A_ADDR, 32'd77, 1);
    xfer(2, A_ADDR, 1'b1, 32'd9, 1'b0);
    chk("lit_ta_9", 2, ta[2], 32'd9);

    // clear coinciding with a write commit
    xfer(1, B_ADDR, 1'b1, 32'd100, 1'b0);
    xfer(1, B_ADDR, 1'b1, 32'd6, 1'b1);
    chk("lit_tb_6", 1, tb[1], 32'd6);
    chk("lit_ta_cleared", 2, ta[2], 32'd0);

    // reset asserted while in the wait phase
    xfer(2, B_ADDR, 1'b1, 32'd21, 1'b0);
    busy = 1'b1; psel[2] = 1'b1; penable = 1'b0;
    paddr = A_ADDR; pwrite = 1'b1; pwdata = 32'd50;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check_reset_values("midreset");
    psel = 3'b000; penable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    xfer(2, A_ADDR, 1'b1, 32'd9, 1'b0);
    chk("lit_ta_9_after_reset", 2, ta[2], 32'd9);
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
